// File: rtl/cpu_pipe_pkg.sv
// Shared payload definitions for the CPU stage-boundary buffers.
// Each stage payload is a packed struct whose width is exported for use as a buffer WIDTH.
package cpu_pipe_pkg;

  localparam int OPCODE_W   = 4;
  localparam int REG_ADDR_W = 6;
  localparam int DATA_W     = 32;
  localparam int IMM_W      = 22;
  localparam int IMM_INC_W  = 16;

  localparam logic [OPCODE_W-1:0] NOP_OPCODE = '0;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [DATA_W-1:0]     rs1_val;
    logic [DATA_W-1:0]     rs2_val;
    logic [IMM_W-1:0]      imm;
    logic [IMM_INC_W-1:0]  imm_inc;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     result;
    logic                  reg_wr;
  } ex_wb_t;

  localparam int IF_ID_W = $bits(if_id_t);
  localparam int ID_EX_W = $bits(id_ex_t);
  localparam int EX_WB_W = $bits(ex_wb_t);

  // Bubble payloads: NOP opcode and no architectural side effects.
  function automatic id_ex_t id_ex_nop();
    id_ex_t p;
    p        = '0;
    p.opcode = NOP_OPCODE;
    return p;
  endfunction

  function automatic ex_wb_t ex_wb_nop();
    ex_wb_t p;
    p        = '0;
    p.opcode = NOP_OPCODE;
    return p;
  endfunction

endpackage

// File: rtl/pipe_stage_buffer.sv
// Elastic stage-boundary register: DEPTH-entry FIFO with valid/ready, stall, flush
// and a NOP bubble on the output whenever the buffer is empty.
module pipe_stage_buffer
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH   = DATA_W,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : NOP_VAL;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty entries are never shown on out_data.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: DEPTH=2 and DEPTH=3 instances checked against a queue model.
module tb_pipe_stage_buffer;

  localparam logic [31:0] NOP_A = 32'h0000_0013;
  localparam logic [31:0] NOP_B = 32'hCAFE_F00D;

  logic        clock, reset_n;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_count;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int vecs = 0;
  int errs = 0;

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(2), .NOP_VAL(NOP_A)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .count(a_count)
  );

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(3), .NOP_VAL(NOP_B)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .count(b_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Upstream protocol: a refused payload must be held until accepted or flushed.
  logic        pend_a = 1'b0, pend_b = 1'b0;
  logic [31:0] pend_da, pend_db;
  always @(posedge clock) begin
    if (reset_n && pend_a) begin
      vecs++;
      if (!(a_in_valid && a_in_data == pend_da)) begin
        $display("FAIL upstream_hold_a: valid=%b data=%h, held data=%h", a_in_valid, a_in_data, pend_da);
        errs++;
      end
    end
    if (reset_n && pend_b) begin
      vecs++;
      if (!(b_in_valid && b_in_data == pend_db)) begin
        $display("FAIL upstream_hold_b: valid=%b data=%h, held data=%h", b_in_valid, b_in_data, pend_db);
        errs++;
      end
    end
    pend_a  = reset_n && a_in_valid && !a_in_ready && !a_flush;
    pend_da = a_in_data;
    pend_b  = reset_n && b_in_valid && !b_in_ready && !b_flush;
    pend_db = b_in_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers: apply inputs at the falling edge, update the model at the rising edge.
  task automatic tick_a(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic push, pop;
    a_in_valid = v; a_in_data = d; a_out_ready = r; a_flush = f;
    push = v && (qa.size() < 2);
    pop  = (qa.size() > 0) && r;
    @(posedge clock);
    if (f) qa.delete();
    else begin
      if (pop)  void'(qa.pop_front());
      if (push) qa.push_back(d);
    end
    @(negedge clock);
  endtask

  task automatic tick_b(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic push, pop;
    b_in_valid = v; b_in_data = d; b_out_ready = r; b_flush = f;
    push = v && (qb.size() < 3);
    pop  = (qb.size() > 0) && r;
    @(posedge clock);
    if (f) qb.delete();
    else begin
      if (pop)  void'(qb.pop_front());
      if (push) qb.push_back(d);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'hDEAD_BEEF; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b1; b_in_data = 32'hDEAD_BEEF; b_out_ready = 1'b0; b_flush = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    reset_n = 1'b1;
    qa.delete(); qb.delete();
    #1;
    vecs += 5;
    if (a_count !== 2'd0)      begin $display("FAIL reset_count: got %0d want 0", a_count); errs++; end
    if (a_out_valid !== 1'b0)  begin $display("FAIL reset_out_valid: got %b want 0", a_out_valid); errs++; end
    if (a_out_data !== NOP_A)  begin $display("FAIL reset_out_data: got %h want %h", a_out_data, NOP_A); errs++; end
    if (a_in_ready !== 1'b1)   begin $display("FAIL reset_in_ready: got %b want 1", a_in_ready); errs++; end
    if (b_out_data !== NOP_B)  begin $display("FAIL reset_out_data_b: got %h want %h", b_out_data, NOP_B); errs++; end
    @(negedge clock);
    vecs += 2;
    if (a_count !== 2'd0) begin $display("FAIL reset_no_capture_a: count %0d want 0", a_count); errs++; end
    if (b_count !== 2'd0) begin $display("FAIL reset_no_capture_b: count %0d want 0", b_count); errs++; end
  endtask

  task automatic test_streaming();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      tick_a(i < 3, 32'(i + 1), 1'b1, 1'b0);
      exp = (qa.size() > 0) ? qa[0] : NOP_A;
      vecs += 4;
      if (a_out_data !== exp) begin $display("FAIL stream_data[%0d]: got %h want %h", i, a_out_data, exp); errs++; end
      if (i < 3 && a_out_data !== 32'(i + 1)) begin $display("FAIL stream_order[%0d]: got %h want %h", i, a_out_data, i + 1); errs++; end
      if (int'(a_count) !== qa.size() || a_count > 2'd1) begin $display("FAIL stream_count[%0d]: got %0d want %0d", i, a_count, qa.size()); errs++; end
      if (a_in_ready !== 1'b1) begin $display("FAIL stream_in_ready[%0d]: got %b want 1", i, a_in_ready); errs++; end
      if (a_out_valid !== (qa.size() > 0)) begin $display("FAIL stream_out_valid[%0d]: got %b want %b", i, a_out_valid, qa.size() > 0); errs++; end
    end
  endtask

  task automatic test_stall_full();
    logic        v[6] = '{1, 1, 1, 1, 1, 0};
    logic [31:0] d[6] = '{32'hA, 32'hB, 32'hC, 32'hC, 32'hC, 32'h0};
    logic        r[6] = '{0, 0, 0, 1, 1, 1};
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      tick_a(v[i], d[i], r[i], 1'b0);
      exp = (qa.size() > 0) ? qa[0] : NOP_A;
      vecs += 4;
      if (a_out_data !== exp) begin $display("FAIL stall_data[%0d]: got %h want %h", i, a_out_data, exp); errs++; end
      if (int'(a_count) !== qa.size()) begin $display("FAIL stall_count[%0d]: got %0d want %0d", i, a_count, qa.size()); errs++; end
      if (a_in_ready !== (qa.size() < 2)) begin $display("FAIL stall_in_ready[%0d]: got %b want %b", i, a_in_ready, qa.size() < 2); errs++; end
      if (a_out_valid !== (qa.size() > 0)) begin $display("FAIL stall_out_valid[%0d]: got %b want %b", i, a_out_valid, qa.size() > 0); errs++; end
    end
  endtask

  task automatic test_flush_priority();
    logic        v[5] = '{1, 1, 1, 1, 0};
    logic [31:0] d[5] = '{32'hA, 32'hB, 32'hC, 32'hD, 32'h0};
    logic        r[5] = '{0, 0, 1, 0, 1};
    logic        f[5] = '{0, 0, 1, 0, 0};
    logic [31:0] exp;
    for (int i = 0; i < 5; i++) begin
      tick_a(v[i], d[i], r[i], f[i]);
      a_flush = 1'b0;
      exp = (qa.size() > 0) ? qa[0] : NOP_A;
      vecs += 3;
      if (a_out_data !== exp) begin $display("FAIL flush_data[%0d]: got %h want %h", i, a_out_data, exp); errs++; end
      if (int'(a_count) !== qa.size()) begin $display("FAIL flush_count[%0d]: got %0d want %0d", i, a_count, qa.size()); errs++; end
      if (a_out_valid !== (qa.size() > 0)) begin $display("FAIL flush_out_valid[%0d]: got %b want %b", i, a_out_valid, qa.size() > 0); errs++; end
      if (i == 3) begin
        vecs++;
        if (a_out_data !== 32'hD) begin $display("FAIL flush_next_head: got %h want 0000000d", a_out_data); errs++; end
      end
    end
  endtask

  task automatic test_wrap();
    int          nxt = 0;
    int          rcv = 0;
    logic        r;
    logic [31:0] exp;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      r = (cyc < 4) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (qb.size() > 0 && r) begin
        vecs++;
        if (b_out_data !== 32'(rcv)) begin $display("FAIL wrap_pop[%0d]: got %h want %h", rcv, b_out_data, rcv); errs++; end
        rcv++;
      end
      if (nxt < 10 && qb.size() < 3) begin
        tick_b(1'b1, 32'(nxt), r, 1'b0);
        nxt++;
      end else begin
        tick_b(nxt < 10, 32'(nxt), r, 1'b0);
      end
      exp = (qb.size() > 0) ? qb[0] : NOP_B;
      vecs += 3;
      if (b_out_data !== exp) begin $display("FAIL wrap_data[%0d]: got %h want %h", cyc, b_out_data, exp); errs++; end
      if (int'(b_count) !== qb.size()) begin $display("FAIL wrap_count[%0d]: got %0d want %0d", cyc, b_count, qb.size()); errs++; end
      if (b_in_ready !== (qb.size() < 3)) begin $display("FAIL wrap_in_ready[%0d]: got %b want %b", cyc, b_in_ready, qb.size() < 3); errs++; end
    end
    b_in_valid = 1'b0;
    vecs += 2;
    if (rcv != 10) begin $display("FAIL wrap_timeout: received %0d want 10", rcv); errs++; end
    if (b_out_valid !== 1'b0) begin $display("FAIL wrap_drained: out_valid %b want 0", b_out_valid); errs++; end
  endtask

  task automatic test_async_reset();
    tick_a(1'b1, 32'h1111, 1'b0, 1'b0);
    tick_a(1'b1, 32'h2222, 1'b0, 1'b0);
    a_in_valid = 1'b0;
    vecs++;
    if (a_count !== 2'd2) begin $display("FAIL areset_precount: got %0d want 2", a_count); errs++; end
    #2 reset_n = 1'b0;
    #1;
    vecs += 4;
    if (a_count !== 2'd0)     begin $display("FAIL areset_count: got %0d want 0", a_count); errs++; end
    if (a_out_valid !== 1'b0) begin $display("FAIL areset_out_valid: got %b want 0", a_out_valid); errs++; end
    if (a_out_data !== NOP_A) begin $display("FAIL areset_out_data: got %h want %h", a_out_data, NOP_A); errs++; end
    if (a_in_ready !== 1'b1)  begin $display("FAIL areset_in_ready: got %b want 1", a_in_ready); errs++; end
    #1 reset_n = 1'b1;
    qa.delete(); qb.delete();
    @(negedge clock);
    vecs += 2;
    if (a_count !== 2'd0)     begin $display("FAIL areset_after_count: got %0d want 0", a_count); errs++; end
    if (a_out_data !== NOP_A) begin $display("FAIL areset_after_data: got %h want %h", a_out_data, NOP_A); errs++; end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_full();
    test_flush_priority();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
